// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID and EX stages: operand widths and
// the packed control word carried down the pipe.
package id_ex_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Field order is also the bit order when the word is viewed as a vector.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jr_control;
        logic [1:0] alu_op;
    } ctrl_word_t;

    // An all-zero control word does no architectural work, so it is the bubble.
    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_sat_counter.sv
// Saturating up-counter with asynchronous clear, used to tally pipeline bubbles.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on each enabled edge, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the flush-gated ID control word, operands
// and register specifiers; supports freeze (hold) and NOP insertion (bubble).
module id_ex_stage #(
    parameter int DATA_W = id_ex_stage_pkg::DATA_W,
    parameter int REG_W  = id_ex_stage_pkg::REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ID_RegDst,
    input  logic              ID_ALUSrc,
    input  logic              ID_MemtoReg,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_Branch,
    input  logic              ID_JRControl,
    input  logic [1:0]        ID_ALUOp,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              hold,
    input  logic              bubble,
    output logic              EX_RegDst,
    output logic              EX_ALUSrc,
    output logic              EX_MemtoReg,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_Branch,
    output logic              EX_JRControl,
    output logic [1:0]        EX_ALUOp,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    import id_ex_stage_pkg::*;

    ctrl_word_t id_ctrl;
    ctrl_word_t ex_ctrl;

    assign id_ctrl = '{
        reg_dst:    ID_RegDst,
        alu_src:    ID_ALUSrc,
        mem_to_reg: ID_MemtoReg,
        reg_write:  ID_RegWrite,
        mem_read:   ID_MemRead,
        mem_write:  ID_MemWrite,
        branch:     ID_Branch,
        jr_control: ID_JRControl,
        alu_op:     ID_ALUOp
    };

    // Pipeline register: hold freezes everything, bubble loads a NOP, else load ID.
    // NOTE: every register here uses <= so all fields update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctrl  <= CTRL_NOP;
            ex_valid <= 1'b0;
            ex_pc4   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else if (hold) begin
            // Upstream stalls too, so the ID instruction waits rather than being lost.
        end else if (bubble) begin
            ex_ctrl  <= CTRL_NOP;
            ex_valid <= 1'b0;
            ex_pc4   <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else begin
            ex_ctrl  <= id_ctrl;
            ex_valid <= id_valid;
            ex_pc4   <= id_pc4;
            ex_rd1   <= id_rd1;
            ex_rd2   <= id_rd2;
            ex_imm   <= id_imm;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
        end
    end

    assign EX_RegDst    = ex_ctrl.reg_dst;
    assign EX_ALUSrc    = ex_ctrl.alu_src;
    assign EX_MemtoReg  = ex_ctrl.mem_to_reg;
    assign EX_RegWrite  = ex_ctrl.reg_write;
    assign EX_MemRead   = ex_ctrl.mem_read;
    assign EX_MemWrite  = ex_ctrl.mem_write;
    assign EX_Branch    = ex_ctrl.branch;
    assign EX_JRControl = ex_ctrl.jr_control;
    assign EX_ALUOp     = ex_ctrl.alu_op;

    // Only bubbles that actually reach the register count; a held bubble does not.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (bubble & ~hold),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. A second instance with CNT_W=4 shares
// the stimulus so counter saturation is reachable in a few cycles.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite;
    logic              ID_MemRead, ID_MemWrite, ID_Branch, ID_JRControl;
    logic [1:0]        ID_ALUOp;
    logic              id_valid;
    logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic              hold, bubble;

    logic              EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite;
    logic              EX_MemRead, EX_MemWrite, EX_Branch, EX_JRControl;
    logic [1:0]        EX_ALUOp;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0]       bubble_cnt;

    logic              s_RegDst, s_ALUSrc, s_MemtoReg, s_RegWrite;
    logic              s_MemRead, s_MemWrite, s_Branch, s_JRControl;
    logic [1:0]        s_ALUOp;
    logic              s_valid;
    logic [DATA_W-1:0] s_pc4, s_rd1, s_rd2, s_imm;
    logic [REG_W-1:0]  s_rs, s_rt, s_rd;
    logic [3:0]        s_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemtoReg(ID_MemtoReg),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_Branch(ID_Branch), .ID_JRControl(ID_JRControl), .ID_ALUOp(ID_ALUOp),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .hold(hold), .bubble(bubble),
        .EX_RegDst(EX_RegDst), .EX_ALUSrc(EX_ALUSrc), .EX_MemtoReg(EX_MemtoReg),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_Branch(EX_Branch), .EX_JRControl(EX_JRControl), .EX_ALUOp(EX_ALUOp),
        .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemtoReg(ID_MemtoReg),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_Branch(ID_Branch), .ID_JRControl(ID_JRControl), .ID_ALUOp(ID_ALUOp),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .hold(hold), .bubble(bubble),
        .EX_RegDst(s_RegDst), .EX_ALUSrc(s_ALUSrc), .EX_MemtoReg(s_MemtoReg),
        .EX_RegWrite(s_RegWrite), .EX_MemRead(s_MemRead), .EX_MemWrite(s_MemWrite),
        .EX_Branch(s_Branch), .EX_JRControl(s_JRControl), .EX_ALUOp(s_ALUOp),
        .ex_valid(s_valid), .ex_pc4(s_pc4), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
        .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .bubble_cnt(s_cnt)
    );

    // Control bits packed as {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,JRControl,ALUOp}.
    function automatic logic [9:0] ex_ctrl_vec();
        return {EX_RegDst, EX_ALUSrc, EX_MemtoReg, EX_RegWrite, EX_MemRead,
                EX_MemWrite, EX_Branch, EX_JRControl, EX_ALUOp};
    endfunction

    task automatic drive_ctrl(input logic [9:0] c);
        {ID_RegDst, ID_ALUSrc, ID_MemtoReg, ID_RegWrite, ID_MemRead,
         ID_MemWrite, ID_Branch, ID_JRControl, ID_ALUOp} = c;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        hold = 1'b0; bubble = 1'b0;
        drive_ctrl(10'b0);
        id_valid = 1'b0;
        id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        #2;
        check("reset_ctrl",  64'(ex_ctrl_vec()), 64'h0);
        check("reset_valid", 64'(ex_valid), 64'h0);
        check("reset_cnt",   64'(bubble_cnt), 64'h0);

        // Load a value, then assert reset between edges.
        step();
        reset_n = 1'b1;
        id_rd1 = 32'hDEAD_BEEF; drive_ctrl(10'b0001_0000_00); id_valid = 1'b1;
        step();
        check("pre_rst_rd1",   64'(ex_rd1), 64'hDEAD_BEEF);
        check("pre_rst_rw",    64'(EX_RegWrite), 64'h1);
        check("pre_rst_valid", 64'(ex_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rd1",   64'(ex_rd1), 64'h0);
        check("async_rst_ctrl",  64'(ex_ctrl_vec()), 64'h0);
        check("async_rst_valid", 64'(ex_valid), 64'h0);
        check("async_rst_cnt",   64'(bubble_cnt), 64'h0);
        step();
        reset_n = 1'b1;

        // Normal load.
        id_rd1 = '0;
        id_pc4 = 32'h0000_0104; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd9;
        drive_ctrl(10'b0001_0000_10); id_valid = 1'b1;
        step();
        check("load_pc4",   64'(ex_pc4), 64'h104);
        check("load_rs",    64'(ex_rs), 64'd3);
        check("load_rt",    64'(ex_rt), 64'd4);
        check("load_rd",    64'(ex_rd), 64'd9);
        check("load_ctrl",  64'(ex_ctrl_vec()), 64'(10'b0001_0000_10));
        check("load_valid", 64'(ex_valid), 64'h1);

        // Three back-to-back bubbles with live control on the inputs.
        bubble = 1'b1; drive_ctrl(10'b0001_0100_00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bubble_ctrl",  64'(ex_ctrl_vec()), 64'h0);
            check("bubble_valid", 64'(ex_valid), 64'h0);
            check("bubble_pc4",   64'(ex_pc4), 64'h0);
            check("bubble_cnt",   64'(bubble_cnt), 64'(i + 1));
        end

        // Hold beats bubble: contents and count stay put while inputs change.
        bubble = 1'b0;
        id_imm = 32'hFFFF_FFF8; drive_ctrl(10'b0101_0000_00); id_valid = 1'b1;
        step();
        check("hold_load_imm", 64'(ex_imm), 64'hFFFF_FFF8);
        hold = 1'b1; bubble = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id_imm = 32'h0000_1234 + 32'(i); drive_ctrl(10'b0000_1000_11); id_valid = 1'b0;
            step();
            check("hold_imm",   64'(ex_imm), 64'hFFFF_FFF8);
            check("hold_ctrl",  64'(ex_ctrl_vec()), 64'(10'b0101_0000_00));
            check("hold_valid", 64'(ex_valid), 64'h1);
            check("hold_cnt",   64'(bubble_cnt), 64'd3);
        end
        hold = 1'b0; bubble = 1'b0;

        // Upstream-flushed word loads as zeros and is not counted.
        drive_ctrl(10'b0); id_valid = 1'b0; id_rd2 = 32'h0000_0005;
        step();
        check("flush_ctrl",  64'(ex_ctrl_vec()), 64'h0);
        check("flush_valid", 64'(ex_valid), 64'h0);
        check("flush_rd2",   64'(ex_rd2), 64'h5);
        check("flush_cnt",   64'(bubble_cnt), 64'd3);
        check("flush_scnt",  64'(s_cnt), 64'd3);

        // Twenty more bubbles: the 4-bit counter reaches 15 after 12 and sticks.
        bubble = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 11) check("sat_reach", 64'(s_cnt), 64'd15);
        end
        check("sat_hold",  64'(s_cnt), 64'd15);
        check("wide_cnt",  64'(bubble_cnt), 64'd23);
        bubble = 1'b0;

        // Resume loading after the bubbles.
        drive_ctrl(10'b1001_0010_01); id_valid = 1'b1; id_rs = 5'd31;
        step();
        check("resume_ctrl",  64'(ex_ctrl_vec()), 64'(10'b1001_0010_01));
        check("resume_rs",    64'(ex_rs), 64'd31);
        check("resume_valid", 64'(ex_valid), 64'h1);
        check("resume_cnt",   64'(bubble_cnt), 64'd23);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
